gpio_param_sequencer: RTL

Host-side write/readback controller for the SPGD parameter bank, driven over one 32-bit GPIO pair.
- Synchronises the PS GPIO word and runs a toggle-handshake command protocol.
- Assembles full-width parameters from two 16-bit halves and drives the parameter bank consumed by the SPGD core.
- Provides per-parameter update strobes, error reporting and a stall timeout.

---
 rtl/gpio_param_sequencer.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/gpio_param_sequencer.sv
// Toggle-handshake GPIO write/readback controller driving the SPGD parameter bank.
// Optional macro PARAM_SHADOW_EN: writes land in a shadow bank that an APPLY command publishes.
module gpio_param_sequencer #(
  parameter int         GPIO_WIDTH     = 32,
  parameter int         PARAM_COUNT    = 16,
  parameter logic [3:0] SET            = 4'd0,
  parameter int         TIMEOUT_CYCLES = 1000000
) (
  input  logic                              CLK,
  input  logic                              RESETN,
  input  logic [GPIO_WIDTH-1:0]             GP_IN,
  output logic [GPIO_WIDTH-1:0]             GP_OUT,
  output logic [PARAM_COUNT*GPIO_WIDTH-1:0] PARAMS_DATA,
  output logic [PARAM_COUNT-1:0]            PARAM_UPD
);
  localparam int W  = GPIO_WIDTH;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, W_LO, W_HI, R_HI} state_t;

  state_t               state_reg, state_next;
  logic [W-1:0]         sync1_reg, sync2_reg;
  logic                 req_prev_reg;
  logic [1:0]           arm_cnt_reg;
  logic [TW-1:0]        timer_reg;
  logic [3:0]           idx_reg, idx_next;
  logic [15:0]          lo_reg, lo_next;
  logic                 ack_reg, ack_next;
  logic                 err_reg, err_next;
  logic [15:0]          rb_reg, rb_next;
  logic [PARAM_COUNT-1:0] upd_reg, upd_next;
  logic [W-1:0]         bank_q [PARAM_COUNT];
  logic [W-1:0]         rd_sel;
  logic [W-1:0]         commit_word;
  logic                 commit_en, apply_en;

  // Command decode straight from the synchronised word
  logic       toggle, hdr_ok, idx_ok, do_apply, expire;
  logic       cmd_wr;
  logic [3:0] cmd_set, cmd_idx, sel_idx;

  assign toggle  = (arm_cnt_reg == 2'd3) && (sync2_reg[W-1] != req_prev_reg);
  assign cmd_wr  = sync2_reg[W-2];
  assign cmd_set = sync2_reg[W-5:W-8];
  assign cmd_idx = sync2_reg[3:0];
  assign hdr_ok  = sync2_reg[W-3] && (cmd_set == SET);
  assign idx_ok  = 32'(cmd_idx) < 32'(PARAM_COUNT);
  assign expire  = (state_reg != IDLE) && !toggle && (timer_reg == TW'(TIMEOUT_CYCLES - 1));
`ifdef PARAM_SHADOW_EN
  assign do_apply = hdr_ok && sync2_reg[W-4];
`else
  assign do_apply = 1'b0;
`endif

  // Hi payload above the lo half; wider words zero-fill, narrower truncate
  assign commit_word = W'({sync2_reg[15:0], lo_reg});
  assign sel_idx     = (state_reg == IDLE) ? cmd_idx : idx_reg;

  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < PARAM_COUNT; i++)
      if (sel_idx == 4'(i)) rd_sel = bank_q[i];
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      sync1_reg    <= '0;
      sync2_reg    <= '0;
      req_prev_reg <= 1'b0;
      arm_cnt_reg  <= 2'd0;
    end else begin
      sync1_reg    <= GP_IN;
      sync2_reg    <= sync1_reg;
      req_prev_reg <= sync2_reg[W-1];
      if (arm_cnt_reg != 2'd3) arm_cnt_reg <= arm_cnt_reg + 2'd1;
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (toggle) begin
      case (state_reg)
        IDLE:    if (hdr_ok && !do_apply && idx_ok) state_next = cmd_wr ? W_LO : R_HI;
        W_LO:    state_next = W_HI;
        default: state_next = IDLE;
      endcase
    end else if (expire) begin
      state_next = IDLE;
    end
  end

  always_comb begin
    ack_next  = ack_reg;
    err_next  = err_reg;
    rb_next   = rb_reg;
    idx_next  = idx_reg;
    lo_next   = lo_reg;
    commit_en = 1'b0;
    apply_en  = 1'b0;
    if (toggle) begin
      ack_next = ~ack_reg;
      err_next = 1'b0;
      case (state_reg)
        IDLE: begin
          if (!hdr_ok)
            err_next = 1'b1;
          else if (do_apply)
            apply_en = 1'b1;
          else if (!idx_ok)
            err_next = 1'b1;
          else begin
            idx_next = cmd_idx;
            if (!cmd_wr) rb_next = rd_sel[15:0];
          end
        end
        W_LO:    lo_next = sync2_reg[15:0];
        W_HI:    commit_en = 1'b1;
        default: rb_next = 16'(rd_sel >> 16);
      endcase
    end else if (expire) begin
      err_next = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      timer_reg <= '0;
      idx_reg   <= '0;
      lo_reg    <= '0;
      ack_reg   <= 1'b0;
      err_reg   <= 1'b0;
      rb_reg    <= '0;
      upd_reg   <= '0;
    end else begin
      timer_reg <= (state_reg == IDLE || toggle || expire) ? '0 : timer_reg + TW'(1);
      idx_reg   <= idx_next;
      lo_reg    <= lo_next;
      ack_reg   <= ack_next;
      err_reg   <= err_next;
      rb_reg    <= rb_next;
      upd_reg   <= upd_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < PARAM_COUNT; gi++) begin : g_entry
      logic         hit;
      logic [W-1:0] value_reg;
      assign hit = (idx_reg == 4'(gi));
`ifdef PARAM_SHADOW_EN
      logic [W-1:0] shadow_reg;
      always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
          shadow_reg <= '0;
          value_reg  <= '0;
        end else begin
          if (commit_en && hit) shadow_reg <= commit_word;
          if (apply_en) value_reg <= shadow_reg;
        end
      end
      assign upd_next[gi] = apply_en && (shadow_reg != value_reg);
`else
      always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN)
          value_reg <= '0;
        else if (commit_en && hit)
          value_reg <= commit_word;
      end
      assign upd_next[gi] = commit_en && hit;
`endif
      assign bank_q[gi] = value_reg;
      assign PARAMS_DATA[gi*W +: W] = value_reg;
    end
  endgenerate

  always_comb begin
    GP_OUT        = '0;
    GP_OUT[W-1]   = ack_reg;
    GP_OUT[W-2]   = err_reg;
    GP_OUT[W-3]   = (state_reg != IDLE);
    GP_OUT[15:0]  = rb_reg;
  end

  assign PARAM_UPD = upd_reg;

  // Command bits outside the decoded fields are don't-care by design
  logic unused_bits;
  assign unused_bits = ^sync2_reg;

endmodule
